// File: rtl/ram_arb_pkg.sv
// Shared types and default parameters for the RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR
  } arb_state_e;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADDR_W      = 11;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_PART_BASE   = 0;
  localparam int DEF_PART_LIMIT  = 1023;
  localparam int DEF_ACK_TIMEOUT = 7;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester at or after ptr, cyclic.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Two passes: [ptr, NUM_REQ-1] first, then wrap to [0, ptr-1].
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (i >= 32'(ptr))) begin
        any       = 1'b1;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i]) begin
        any       = 1'b1;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters,
// with partition bounds check and write-ack timeout.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PART_BASE   = DEF_PART_BASE,
  parameter int PART_LIMIT  = DEF_PART_LIMIT,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data,
  input  logic                      mem_wr_ack,
  input  logic [DATA_W-1:0]         mem_rd_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef logic signed [ADDR_W:0] saddr_t;
  localparam saddr_t BASE_S  = saddr_t'(PART_BASE);
  localparam saddr_t LIMIT_S = saddr_t'(PART_LIMIT);

  arb_state_e         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_any;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               in_range;
  logic [3:0]         tmo_cnt;
  logic [NUM_REQ-1:0] idx_onehot;
  logic [IDX_W-1:0]   next_ptr;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Signed compare with one extra bit keeps a zero base from folding to constant.
  assign in_range   = (saddr_t'({1'b0, sel_addr}) >= BASE_S) &&
                      (saddr_t'({1'b0, sel_addr}) <= LIMIT_S);
  assign idx_onehot = NUM_REQ'(1) << idx_q;
  assign next_ptr   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      tmo_cnt   <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            idx_q  <= pick_idx;
            we_q   <= sel_we;
            addr_q <= sel_addr;
            data_q <= sel_wdata;
            gnt    <= pick_onehot;
            if (in_range) begin
              mem_wr_en <= sel_we;
              mem_rd_en <= !sel_we;
              state     <= ISSUE;
            end else begin
              state <= ERR;
            end
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (!we_q) begin
            rdata <= mem_rd_data;
            done  <= idx_onehot;
            state <= DONE;
          end else if (mem_wr_ack) begin
            done  <= idx_onehot;
            state <= DONE;
          end else if (tmo_cnt >= 4'(ACK_TIMEOUT - 1)) begin
            done  <= idx_onehot;
            err   <= 1'b1;
            state <= DONE;
          end else if (tmo_cnt != 4'hF) begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        ERR: begin
          done  <= idx_onehot;
          err   <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one port of the dual-port 2 KB partitioned RAM among up to NUM_REQ requesters on a single clock domain. It latches the winning request, bounds-checks the address against the port's partition, and issues exactly one RAM strobe per access. It completes each access using the RAM's write acknowledge or its one-cycle read latency, then returns done, error and read data to the requester. One instance sits in front of each RAM port.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 11, RAM address width
- DATA_W, 8, RAM data width
- PART_BASE, 0, lowest legal address for this port
- PART_LIMIT, 1023, highest legal address for this port (inclusive)
- ACK_TIMEOUT, 7, WAIT cycles without wr_ack before flagging error (1..15)

- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request, level
- we  in  NUM_REQ  per-requester 1 = write, 0 = read
- addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_REQ*DATA_W  flattened write data
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: request accepted and latched
- done  out  NUM_REQ  one-hot, one-cycle pulse: access finished
- err  out  1  valid with done: out-of-partition address or write timeout
- rdata  out  DATA_W  read data, valid with done for a successful read
- mem_wr_en, mem_rd_en  out  1 each  RAM strobes
- mem_addr  out  ADDR_W  RAM address
- mem_data  out  DATA_W  RAM write data
- mem_wr_ack  in  1  RAM write acknowledge
- mem_rd_data  in  DATA_W  RAM read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: if any req is high, select the first requester at or after rr_ptr (cyclic), latch we/addr/wdata/index, and pulse gnt.
  - Address outside [PART_BASE, PART_LIMIT] -> ERR. Otherwise -> ISSUE.
- ISSUE: one cycle. Drive mem_wr_en or mem_rd_en with mem_addr/mem_data from the latched values -> WAIT.
- WAIT: write completes on mem_wr_ack. A read completes unconditionally on its first WAIT cycle, capturing mem_rd_data. If a write sees no ack within ACK_TIMEOUT cycles, set err -> DONE.
- DONE / ERR: pulse done[idx]; err=1 in ERR or on timeout; rdata updates only on a successful read. Set rr_ptr = idx+1 mod NUM_REQ -> IDLE.
- ERR paths never assert either RAM strobe.
- A requester holds req/we/addr/wdata stable until gnt. After gnt it may change them. Keeping req high after done is a new request.
- Simultaneous requests: exactly one gnt. The others wait; none is lost.

## Timing
- Reset values: all outputs 0, rr_ptr=0, state IDLE. Reset mid-access aborts it: no done is issued and strobes drop immediately.
- req sampled at edge E0 -> gnt and the strobe are high in cycle 1 (ISSUE). RAM samples at E1. The arbiter samples mem_wr_ack/mem_rd_data at E2. done is high in cycle 3.
  - Read latency is 3 cycles from the req edge.
  - Out-of-range latency is 2 cycles (gnt in cycle 1, done+err in cycle 2).
- mem_* strobes are exactly one cycle wide, and mem_wr_en and mem_rd_en are never high together.
- The timeout counter is 4 bits, cleared on entry to WAIT, and saturates.
- Throughput: one access per 4 cycles, with the DONE cycle followed by IDLE arbitration.

## Structure
- Package ram_arb_pkg holds the state enum (IDLE, ISSUE, WAIT, DONE, ERR) and the default width/partition constants.
- Sub-module rr_picker holds the combinational round-robin selector (req, rr_ptr -> one-hot plus index) and is reused by other shared-resource blocks.

## Test plan
- Write, then read back. Requester 0 writes 0xC3 to address 115; the RAM acks on the next cycle -> done[0] in cycle 3 with err=0. A subsequent read of 115 -> rdata=0xC3 with done[0].
- Simultaneous requests. Raise req[3:0]=4'b1111 in the same cycle with rr_ptr=0 -> gnt order 0,1,2,3, one access per 4 cycles. A later lone req[0] still wins.
- Fairness. Hold req[1] and req[2] continuously -> grants alternate 1,2,1,2. No requester is granted twice while another waits.
- Out-of-range. Requester 2 writes 0x01 to 1025 with PART_LIMIT=1023 -> gnt[2], then done[2]+err=1 the next cycle. mem_wr_en never rises and RAM contents are unchanged.
- Write timeout. Tie mem_wr_ack=0 -> done+err after 7 WAIT cycles, then the arbiter returns to IDLE and serves the next request normally.
- Reset mid-access. Drop reset during WAIT of a read -> all outputs 0 asynchronously, no done. After release, rr_ptr=0 and requester 0 is served first.
